// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - default gap and busy-timeout constants
//   - width helpers for requester indices and saturating counters
// No ports; imported by rr_pick and uart_tx_arb.
package uart_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam int DEF_GAP_TICKS = 16;
  localparam int DEF_BUSY_TO   = 15;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal <= 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req_i starting at ptr_i and
// wrapping modulo NREQ; the first set bit wins.
// Ports:
//   req_i    [NREQ-1:0]  request vector
//   ptr_i    [IW-1:0]    index with highest priority this round
//   valid_o              at least one request is set
//   grant_o  [IW-1:0]    index of the winning requester
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   grant_o
);

  int idx;

  // Walk the offsets from farthest to nearest so the requester closest to
  // the pointer is the last one written and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter sharing one 8-bit UART transmitter between NREQ
// clients. Captures the winner's byte, pulses tx_start, follows tx_busy
// through the frame, then holds off for GAP_TICKS bd8_rate ticks.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   bd8_rate               one-clk pulse at 8x baud
//   req      [NREQ-1:0]    per-client request, held with data until ack
//   req_data [8*NREQ-1:0]  client i byte in bits [8i+7:8i]
//   ack      [NREQ-1:0]    one-clk pulse, byte of that client captured
//   tx_start               one-clk start pulse to the TX engine
//   tx_data  [7:0]         captured byte, stable until the next grant
//   tx_busy                TX engine frame in progress
//   owner    [IW-1:0]      index of the last granted client
//   arb_busy               high whenever the FSM is not idle
//   tx_timeout             one-clk pulse when tx_busy never rose
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int BUSY_TO   = DEF_BUSY_TO,
  localparam int IW = idxWidth(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bd8_rate,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [IW-1:0]     owner,
  output logic              arb_busy,
  output logic              tx_timeout
);

  localparam int BW = cntWidth(BUSY_TO);
  localparam int GW = cntWidth(GAP_TICKS);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            txStart_q, txStart_d;
  logic [7:0]      txData_q, txData_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            txTimeout_q, txTimeout_d;
  logic [BW-1:0]   busyCnt_q, busyCnt_d;
  logic [GW-1:0]   gapCnt_q, gapCnt_d;

  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  logic            busyLimit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pickValid),
    .grant_o (pickIdx)
  );

  // The timeout fires on the cycle that would bring the count to BUSY_TO,
  // so the pulse lands exactly BUSY_TO cycles after tx_start.
  assign busyLimit = (int'(busyCnt_q) + 1) >= BUSY_TO;

  // Next-state logic. ack, tx_start and tx_timeout default low so each is a
  // single-cycle pulse; tx_data and owner hold until the next grant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    txStart_d   = 1'b0;
    txData_d    = txData_q;
    owner_d     = owner_q;
    txTimeout_d = 1'b0;
    busyCnt_d   = busyCnt_q;
    gapCnt_d    = gapCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pickValid && !tx_busy) begin
          txData_d  = req_data[int'(pickIdx) * 8 +: 8];
          owner_d   = pickIdx;
          ack_d     = NREQ'(1) << pickIdx;
          txStart_d = 1'b1;
          ptr_d     = (int'(pickIdx) == NREQ - 1) ? '0 : pickIdx + 1'b1;
          busyCnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (busyLimit) begin
          txTimeout_d = 1'b1;
          gapCnt_d    = '0;
          state_d     = ST_GAP;
        end else if (int'(busyCnt_q) < BUSY_TO) begin
          busyCnt_d = busyCnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          gapCnt_d = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (int'(gapCnt_q) >= GAP_TICKS) begin
          state_d = ST_IDLE;
        end else if (bd8_rate) begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ack_q       <= '0;
      txStart_q   <= 1'b0;
      txData_q    <= '0;
      owner_q     <= '0;
      txTimeout_q <= 1'b0;
      busyCnt_q   <= '0;
      gapCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      txStart_q   <= txStart_d;
      txData_q    <= txData_d;
      owner_q     <= owner_d;
      txTimeout_q <= txTimeout_d;
      busyCnt_q   <= busyCnt_d;
      gapCnt_q    <= gapCnt_d;
    end
  end

  assign ack        = ack_q;
  assign tx_start   = txStart_q;
  assign tx_data    = txData_q;
  assign owner      = owner_q;
  assign tx_timeout = txTimeout_q;
  assign arb_busy   = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter that shares one 8-bit UART transmitter between NREQ byte requesters. It captures the winning requester's byte, issues a one-cycle start to the transmitter, and tracks the transmitter's busy flag through the frame. It then enforces a minimum inter-frame idle gap, counted in 8x-baud ticks, before granting again. It sits between the protocol clients and the UART TX engine, sharing the bd8_rate tick with the UART receiver.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_TICKS, 16, minimum idle gap after a frame in bd8_rate ticks (0 = no gap)
BUSY_TO, 15, clk cycles allowed for tx_busy to rise after tx_start

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
bd8_rate  input  1  one-clk pulse at 8x baud rate
req  input  NREQ  request per client; hold high with data stable until ack
req_data  input  8*NREQ  client i byte in bits [8i+7:8i]
ack  output  NREQ  one-clk pulse, byte of client i captured
tx_start  output  1  one-clk pulse to TX engine
tx_data  output  8  byte to transmit; stable from tx_start until next grant
tx_busy  input  1  TX engine frame in progress
owner  output  $clog2(NREQ)  index of last granted client
arb_busy  output  1  high in every state except IDLE
tx_timeout  output  1  one-clk pulse, tx_busy never rose

Behaviour:
- Reset (rst_n low, async): state IDLE; ack=0, tx_start=0, tx_data=0, owner=0, tx_timeout=0; rr pointer ptr=0; counters 0. Reset mid-frame abandons the frame; no further tx_start is issued.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE: grant when req!=0 and tx_busy==0.
  - Winner g is the first set req bit searching ptr, ptr+1, ... with wrap mod NREQ.
  - On that edge: tx_data<=req_data[g], owner<=g, ack[g]<=1, tx_start<=1, ptr<=(g+1) mod NREQ, state<=START.
  - Latency: req seen at edge k gives ack/tx_start high for exactly the cycle after edge k.
- IDLE hold: with tx_busy high, no grant is made and state stays IDLE.
- START: ack and tx_start return to 0. A cycle counter counts clk cycles.
  - tx_busy==1 -> WAIT_DONE.
  - Counter reaches BUSY_TO with tx_busy still 0 -> tx_timeout pulse 1 cycle, then to GAP.
- WAIT_DONE: tx_busy==0 -> GAP with gap counter cleared. There is no timeout in WAIT_DONE.
- GAP:
  - Gap counter increments on each bd8_rate pulse.
  - Gap counter == GAP_TICKS -> IDLE.
  - GAP_TICKS==0 -> leave GAP on the first cycle, so the gap costs one clk.
- Fairness: a client keeping req high is served again only after every other active requester has had one grant.
- Request withdrawal: a req dropped before ack means nothing is sent and no ack is given. A req raised in the same cycle as the grant edge of another client waits for the next arbitration.
- Per-grant delivery: exactly one byte per ack. A client holding req after ack requests another byte.
- Counter widths: sized for BUSY_TO and GAP_TICKS; counters saturate and never wrap.
- Reset domains: all outputs are registered; no combinational path from req to ack or tx_start.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE=0, START=1, WAIT_DONE=2, GAP=3.
  - Default GAP_TICKS and BUSY_TO constants.
  - Index width function, clog2 of NREQ.
- Sub-module rr_pick: combinational; inputs req[NREQ] and ptr; outputs valid and the winner index g.
- The FSM, counters and output registers stay in uart_tx_arb.

Test Plan:
- Single request: after reset, req=4'b0100, req_data[23:16]=8'hA5, tx_busy=0 -> next cycle ack=4'b0100, tx_start=1, tx_data=8'hA5, owner=2; no second tx_start until tx_busy has risen and fallen and the gap has elapsed.
- Round-robin: req=4'b1111 held, TX model busy 20 cycles per frame -> grant order 0,1,2,3,0,1; owner follows that sequence; exactly one ack per grant.
- Gap enforcement: GAP_TICKS=16, tx_busy falls at cycle T, req pending -> no tx_start until the 16th bd8_rate pulse after T; GAP_TICKS=0 -> tx_start 2 cycles after the fall.
- Timeout: TX model never asserts tx_busy, BUSY_TO=15 -> tx_timeout pulses once, 15 cycles after tx_start; FSM passes through GAP and the next requester is granted normally.
- Busy hold and withdrawal: tx_busy held high in IDLE with req=4'b0001 -> no ack; drop req before tx_busy falls -> no ack and no tx_start at all.
- Reset mid-frame: rst_n low during WAIT_DONE -> all outputs 0 and ptr=0 immediately; after release, req=4'b1001 -> client 0 granted first, then client 3.
